// File: rtl/lsu_io_bridge.sv
// lsu_io_bridge: single-outstanding LSU bridge to data memory and memory-mapped IO
module lsu_io_bridge #(
  parameter logic [31:0] IO_BASE = 32'h8000_0000,
  parameter logic [31:0] IO_MASK = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] io_addr,
  output logic        io_we,
  output logic [3:0]  io_be,
  output logic [31:0] io_wdata,
  input  logic [31:0] io_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d, uns_q, uns_d, io_q, io_d, err_q, err_d;
  logic        bad, issue_io, issue_dm;
  logic [3:0]  be;
  logic [31:0] wrep, raw, lane, ext;
  assign bad = (req_size == 2'd3) || (req_size == 2'd1 && req_addr[0]) ||
               (req_size == 2'd2 && req_addr[1:0] != 2'd0);
  assign be = size_q == 2'd0 ? 4'b0001 << addr_q[1:0] :
              size_q == 2'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wrep = size_q == 2'd0 ? {4{wdata_q[7:0]}} :
                size_q == 2'd1 ? {2{wdata_q[15:0]}} : wdata_q;
  assign raw  = io_q ? io_rdata : dmem_rdata;
  assign lane = size_q == 2'd0 ? raw >> {addr_q[1:0], 3'b000} : raw >> {addr_q[1], 4'b0000};
  assign ext  = size_q == 2'd0 ? {{24{~uns_q & lane[7]}}, lane[7:0]} :
                size_q == 2'd1 ? {{16{~uns_q & lane[15]}}, lane[15:0]} : raw;
  assign issue_io   = state_q == ISSUE && io_q;
  assign issue_dm   = state_q == ISSUE && !io_q;
  assign req_ready  = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_rdata = resp_valid ? rdata_q : 32'd0;
  assign resp_err   = resp_valid && err_q;
  assign io_addr    = issue_io ? addr_q : 32'd0;
  assign io_we      = issue_io && we_q;
  assign io_be      = issue_io ? be : 4'd0;
  assign io_wdata   = issue_io ? wrep : 32'd0;
  assign dmem_addr  = issue_dm ? {addr_q[31:2], 2'b00} : 32'd0;
  assign dmem_we    = issue_dm && we_q;
  assign dmem_be    = issue_dm ? be : 4'd0;
  assign dmem_wdata = issue_dm ? wrep : 32'd0;
  // next state: capture on accept, extract load data while waiting, single-cycle response
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    size_d  = size_q;
    we_d    = we_q;
    uns_d   = uns_q;
    io_d    = io_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d  = req_addr;
        wdata_d = req_wdata;
        size_d  = req_size;
        we_d    = req_we;
        uns_d   = req_unsigned;
        io_d    = (req_addr & IO_MASK) == IO_BASE;
        err_d   = bad;
        rdata_d = 32'd0;
        state_d = bad ? RESP : ISSUE;
      end
      ISSUE: state_d = we_q ? RESP : WAIT;
      WAIT: begin
        rdata_d = ext;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and request registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      io_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      io_q    <= io_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_lsu_io_bridge.sv
// tb_lsu_io_bridge: table-driven check of decode, lanes, extension, latency and reset abort
module tb_lsu_io_bridge;
  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0, dmem_rdata = '0, io_rdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_ready, resp_valid, resp_err, dmem_we, io_we;
  logic [31:0] resp_rdata, dmem_addr, dmem_wdata, io_addr, io_wdata;
  logic [3:0]  dmem_be, io_be;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  lsu_io_bridge dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .dmem_addr(dmem_addr),
    .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .io_addr(io_addr), .io_we(io_we), .io_be(io_be),
    .io_wdata(io_wdata), .io_rdata(io_rdata)
  );
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic        io;
    logic [3:0]  be;
    logic [31:0] ewdata;
    logic [31:0] erdata;
  } vec_t;
  vec_t tbl[12];
  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask
  task automatic bus_idle(input string name, input int idx);
    chk({name, "_dm_we"}, idx, {31'd0, dmem_we}, 32'd0);
    chk({name, "_io_we"}, idx, {31'd0, io_we}, 32'd0);
    chk({name, "_be"}, idx, {24'd0, dmem_be, io_be}, 32'd0);
    chk({name, "_addr"}, idx, dmem_addr | io_addr, 32'd0);
    chk({name, "_wdata"}, idx, dmem_wdata | io_wdata, 32'd0);
  endtask
  task automatic run(input vec_t v, input int idx);
    int lat, exp_lat;
    @(negedge clk);
    chk("ready_idle", idx, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_size = v.size;
    req_unsigned = v.uns; req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0; req_we = ~v.we; req_addr = 32'hDEAD_BEEF; req_size = 2'd3;
    req_unsigned = ~v.uns; req_wdata = 32'h5A5A_A5A5;
    io_rdata   = v.io ? v.rdata : ~v.rdata;
    dmem_rdata = v.io ? ~v.rdata : v.rdata;
    if (v.err) bus_idle("err_bus", idx);
    else begin
      chk("io_we", idx, {31'd0, io_we}, {31'd0, v.io & v.we});
      chk("dmem_we", idx, {31'd0, dmem_we}, {31'd0, ~v.io & v.we});
      chk("io_be", idx, {28'd0, io_be}, v.io ? {28'd0, v.be} : 32'd0);
      chk("dmem_be", idx, {28'd0, dmem_be}, v.io ? 32'd0 : {28'd0, v.be});
      chk("io_addr", idx, io_addr, v.io ? v.addr : 32'd0);
      chk("dmem_addr", idx, dmem_addr, v.io ? 32'd0 : {v.addr[31:2], 2'b00});
      chk("io_wdata", idx, io_wdata, v.io ? v.ewdata : 32'd0);
      chk("dmem_wdata", idx, dmem_wdata, v.io ? 32'd0 : v.ewdata);
    end
    lat = 1;
    while (!resp_valid && lat < 6) begin
      @(negedge clk);
      lat++;
      if (!resp_valid) bus_idle("wait_bus", idx);
    end
    exp_lat = v.err ? 1 : v.we ? 2 : 3;
    chk("latency", idx, lat, exp_lat);
    chk("resp_err", idx, {31'd0, resp_err}, {31'd0, v.err});
    chk("resp_rdata", idx, resp_rdata, v.erdata);
    chk("ready_resp", idx, {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("resp_done", idx, {31'd0, resp_valid}, 32'd0);
    chk("rdata_clear", idx, resp_rdata | {31'd0, resp_err}, 32'd0);
  endtask
  initial begin
    //              we    addr          sz    uns   wdata         rdata         err   io    be       ewdata        erdata
    tbl[0]  = '{1'b1, 32'h8000_0014, 2'd2, 1'b0, 32'h0000_0001, 32'h0,        1'b0, 1'b1, 4'b1111, 32'h0000_0001, 32'h0};
    tbl[1]  = '{1'b0, 32'h0000_0103, 2'd0, 1'b0, 32'h0,        32'h80AA_5511, 1'b0, 1'b0, 4'b1000, 32'h0,         32'hFFFF_FF80};
    tbl[2]  = '{1'b0, 32'h0000_0103, 2'd0, 1'b1, 32'h0,        32'h80AA_5511, 1'b0, 1'b0, 4'b1000, 32'h0,         32'h0000_0080};
    tbl[3]  = '{1'b1, 32'h0000_0202, 2'd1, 1'b0, 32'h1234_BEEF, 32'h0,        1'b0, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    tbl[4]  = '{1'b0, 32'h0000_0202, 2'd1, 1'b0, 32'h0,        32'h8001_0000, 1'b0, 1'b0, 4'b1100, 32'h0,         32'hFFFF_8001};
    tbl[5]  = '{1'b0, 32'h8000_0002, 2'd2, 1'b0, 32'h0,        32'h1111_1111, 1'b1, 1'b1, 4'b0000, 32'h0,         32'h0};
    tbl[6]  = '{1'b0, 32'h0000_0000, 2'd3, 1'b0, 32'h0,        32'h2222_2222, 1'b1, 1'b0, 4'b0000, 32'h0,         32'h0};
    tbl[7]  = '{1'b0, 32'h8000_0000, 2'd2, 1'b0, 32'h0,        32'h0000_0001, 1'b0, 1'b1, 4'b1111, 32'h0,         32'h0000_0001};
    tbl[8]  = '{1'b1, 32'h8000_0005, 2'd0, 1'b0, 32'h0000_00AB, 32'h0,        1'b0, 1'b1, 4'b0010, 32'hABAB_ABAB, 32'h0};
    tbl[9]  = '{1'b0, 32'h0000_0200, 2'd1, 1'b1, 32'h0,        32'h1234_F00D, 1'b0, 1'b0, 4'b0011, 32'h0,         32'h0000_F00D};
    tbl[10] = '{1'b1, 32'h0000_0201, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,         32'h0};
    tbl[11] = '{1'b0, 32'h0000_0100, 2'd0, 1'b0, 32'h0,        32'h0000_007F, 1'b0, 1'b0, 4'b0001, 32'h0,         32'h0000_007F};
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", -1, {31'd0, req_ready}, 32'd1);
    chk("rst_resp", -1, {30'd0, resp_valid, resp_err}, 32'd0);
    chk("rst_rdata", -1, resp_rdata, 32'd0);
    bus_idle("rst_bus", -1);
    for (int i = 0; i < 12; i++) run(tbl[i], i);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0000; req_size = 2'd2; req_unsigned = 1'b0;
    io_rdata = 32'h0000_0001;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_issue", 12, {31'd0, io_be[0]}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready", 12, {31'd0, req_ready}, 32'd1);
    chk("abort_noresp", 12, {31'd0, resp_valid}, 32'd0);
    bus_idle("abort_bus", 12);
    repeat (3) begin
      @(negedge clk);
      chk("abort_quiet", 12, {31'd0, resp_valid}, 32'd0);
    end
    run(tbl[7], 13);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lsu_io_bridge.md
Name: lsu_io_bridge

Overview:
- Sits between the core's load/store unit and the two data-side slaves: data memory and the memory-mapped IO block (buttons/LEDs at 0x8000_0000 upward).
- Accepts one load/store request at a time, decodes the target region, and generates byte enables and lane-replicated write data.
- Drives exactly one bus strobe cycle, captures the slave's 1-cycle-latency read data, and returns size/sign-adjusted load data.
- Flags misaligned or illegal-size accesses without touching either bus.

Parameters:
IO_BASE, 32'h8000_0000, region match value for IO
IO_MASK, 32'h8000_0000, address bits compared against IO_BASE; IO selected when (addr & IO_MASK) == IO_BASE, otherwise DMEM

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
req_valid  in  1  core request strobe
req_ready  out  1  bridge can accept; high only in IDLE
req_we  in  1  1=store, 0=load
req_addr  in  32  byte address
req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
req_unsigned  in  1  zero-extend load (lbu/lhu)
req_wdata  in  32  store data, LSB-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  valid with resp_valid; misaligned or illegal size
dmem_addr  out  32  word-aligned address (addr[1:0]=0)
dmem_we  out  1  store strobe
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_rdata  in  32  registered read data, valid cycle after address
io_addr  out  32  full byte address (IO decodes low nibble)
io_we  out  1  store strobe
io_be  out  4  byte enables
io_wdata  out  32  lane-replicated store data
io_rdata  in  32  registered read data, valid cycle after address

Behaviour:
- Reset: state=IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_err=0; all dmem_*/io_* outputs 0; internal request regs cleared.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. When req_valid=1, capture addr, we, size, unsigned, wdata and region select.
  - Error check: size=3; size=1 with addr[0]=1; size=2 with addr[1:0]!=0. Any error -> RESP with err=1.
  - Otherwise -> ISSUE.
- ISSUE (exactly 1 cycle): drive only the selected slave's addr/be/wdata; we = captured we. The non-selected slave sees all zeros. Store -> RESP; load -> WAIT.
- WAIT: bus outputs back to 0. Sample the selected slave's rdata and extract -> RESP.
- RESP: resp_valid=1 for 1 cycle, with resp_rdata/resp_err stable that cycle. -> IDLE. resp_rdata=0 and resp_err=0 outside RESP.
- Latency from accept edge: misaligned/illegal = resp at cycle +1; store = +2; load = +3. No back-to-back accepts; the next accept happens at the earliest in the cycle after RESP.
- Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<(2*addr[1]); word = 4'b1111.
- Write data: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- Load extract: byte lane = rdata >> (8*addr[1:0]); half lane = rdata >> (16*addr[1]). Sign-extend from bit 7/15 unless req_unsigned; word passes through (req_unsigned ignored).
- io_addr carries the full byte address; dmem_addr is word-aligned.
- req_* inputs are ignored outside IDLE. req_valid held high after resp causes a new accept in IDLE.
- Reset mid-transaction (any state): return to IDLE next edge, bus strobes deasserted, no resp_valid pulse.
- Errors never assert any we or be.

Test Plan:
- Word store to IO LED1: addr 0x8000_0014, size 2, wdata 0x0000_0001 -> cycle +1 io_we=1, io_be=4'b1111, io_addr=0x8000_0014, dmem_we=0; resp_valid at +2, resp_err=0, resp_rdata=0.
- Signed byte load from DMEM: addr 0x0000_0103, size 0, dmem_rdata 0x80AA_5511 -> dmem_addr=0x0000_0100; resp_valid at +3, resp_rdata=0xFFFF_FF80. Same access with req_unsigned=1 -> 0x0000_0080.
- Half store to DMEM: addr 0x0000_0202, wdata 0x1234_BEEF -> dmem_be=4'b1100, dmem_wdata=0xBEEF_BEEF.
- Signed half load: addr 0x0000_0202, rdata 0x8001_0000 -> resp_rdata=0xFFFF_8001.
- Misaligned word load: addr 0x8000_0002 -> resp_valid at +1, resp_err=1, resp_rdata=0, no io/dmem strobe. Size 3 at 0x0000_0000 -> resp_err=1.
- Button read then reset mid-op: load 0x8000_0000 with io_rdata=1 -> resp_rdata=1. Then a new load with reset asserted during WAIT -> no resp_valid, req_ready=1 the cycle after reset, all bus outputs 0.
